simd_addsub_stream: RTL and testbench
=====================================

# simd_addsub_stream

Parametrised successor to the fixed 4×11-bit packed adder blackbox. It pulls one packed word from each of two HLS FIFO streams per call and applies a per-call add or subtract on LANES independent W-bit lanes, mapping onto DSP SIMD. A full ap_ctrl_chain FSM (start/ready/done/idle/continue) lets it drop into HLS dataflow regions as a blackbox. Per-lane signed overflow flags are reported with every result.

## Interface
- LANES, 4: number of packed lanes.
- W, 11: lane width in bits; lanes are signed two's complement.
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_ce  in  1  clock enable; when low, all state, outputs and read strobes are frozen or low.
- ap_start, ap_continue  in  1  block-level control.
- ap_ready, ap_done, ap_idle  out  1  block-level status.
- op  in  1  0 = a+b, 1 = a−b; sampled with the operands.
- a_dout, b_dout  in  LANES*W  FIFO data; lane i = bits [i*W +: W].
- a_empty_n, b_empty_n  in  1  FIFO not-empty.
- a_read, b_read  out  1  FIFO pop strobes.
- z  out  LANES*W  packed result, registered.
- z_ovf  out  LANES  per-lane signed-overflow flag, registered.
- z_ap_vld  out  1  result-valid pulse.

## Operation
- FSM states: IDLE, WAIT_IN, EXEC, DONE. All outputs reset to 0; the FSM resets to IDLE.
- Fire condition: ap_ce=1, a_empty_n=1, b_empty_n=1, and either state=WAIT_IN or (state=IDLE and ap_start=1).
- On fire: a_read, b_read and ap_ready are high combinationally in that cycle; a_dout, b_dout and op are captured; next state is EXEC.
- Streams are only popped jointly; if exactly one stream is non-empty, neither is popped.
- IDLE with ap_start=1 but no fire: next state is WAIT_IN.
- EXEC: each lane computes z_i = a_i ± b_i; z, z_ovf and z_ap_vld are registered; next state is DONE.
- DONE: ap_done=1 and z/z_ovf are held stable. On ap_continue=1, next state is IDLE. ap_start is ignored in DONE.
- ap_idle=1 only in IDLE.
- Arithmetic: compute in W+1 bits. z_ovf[i]=1 when the true signed result is outside [−2^(W−1), 2^(W−1)−1].
- Asynchronous reset is honoured in any state, mid-operation included: outputs clear immediately, nothing popped afterwards.

## Timing
- Fire at cycle t → z_ap_vld high for exactly cycle t+2, ap_done high from t+2.
- Back-to-back calls: continue at t+2 → IDLE at t+3 → next fire at t+3 at the earliest.
- ap_ce=0 stretches every stage by the number of low cycles; a_read/b_read are never high while ap_ce=0.

## Configuration
- SIMD_ADDSUB_SAT_EN defined: each lane saturates to 2^(W−1)−1 or −2^(W−1) on overflow.
- Undefined: each lane wraps modulo 2^W.
- z_ovf has identical meaning in both builds.

## Structure
- Package simd_stream_pkg holds:
  - the FSM state enum (ctrl_state_t);
  - default LANES/W localparams;
  - OP_ADD/OP_SUB constants;
  - a sat_clip function.
- Sub-module simd_lane_alu: one W-bit lane add/sub plus overflow/saturation, instantiated LANES times via generate.

## Test plan
All cases use W=11, LANES=4.
- Add: a={1,2,3,1023}, b={1,1,1,1}, op=0, fire at t → z_ap_vld at t+2 only; z={2,3,4,−1024 wrap | 1023 sat}; z_ovf=4'b1000.
- Sub: a={0,−1024,5,0}, b={1,1,5,0}, op=1 → z={−1,1023 wrap | −1024 sat,0,0}; z_ovf=4'b0010.
- Stall: ap_start=1, a_empty_n=0 for 5 cycles → WAIT_IN, ap_idle=0, no reads; a_empty_n→1 → single read pulse, z two cycles later.
- Hold: ap_continue=0 for 10 cycles after done, FIFOs non-empty, ap_start=1 → ap_done=1 and z constant throughout; zero reads until continue.
- CE: ap_ce=0 for 3 cycles during EXEC → z_ap_vld at t+5; all outputs frozen meanwhile.
- Reset: ap_rst_n low mid-EXEC → z=0, z_ovf=0, ap_idle=0 at once; after release IDLE, ap_idle=1, no pops without ap_start.

Source files
------------

// File: rtl/simd_stream_pkg.sv
// simd_stream_pkg: shared types, defaults and helpers for simd_addsub_stream
package simd_stream_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_IN, EXEC, DONE} ctrl_state_t;

    localparam int DEF_LANES = 4;
    localparam int DEF_W     = 11;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Clip a sign-extended (w+1)-bit result to the w-bit signed range; callers keep the low w bits
    function automatic logic [63:0] sat_clip(input logic [64:0] s, input int w);
        logic [63:0] mx;
        mx = (64'd1 << (w - 1)) - 64'd1;
        return (s[w] == s[w-1]) ? s[63:0] : (s[w] ? ~mx : mx);
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// simd_lane_alu: one signed W-bit add/sub lane with overflow flag; saturates when SIMD_ADDSUB_SAT_EN is defined, wraps otherwise
module simd_lane_alu
    import simd_stream_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic [W-1:0] r,
    output logic         ovf
);

    logic [W:0] s;

    assign s   = (op == OP_SUB) ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    assign ovf = s[W] ^ s[W-1];

`ifdef SIMD_ADDSUB_SAT_EN
    assign r = W'(sat_clip({{(64-W){s[W]}}, s}, W));
`else
    assign r = s[W-1:0];
`endif

endmodule

// File: rtl/simd_addsub_stream.sv
// simd_addsub_stream: ap_ctrl_chain SIMD add/sub over two FIFO streams (SIMD_ADDSUB_SAT_EN selects saturating lanes)
module simd_addsub_stream
    import simd_stream_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = DEF_W
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_ce,
    input  logic               ap_start,
    input  logic               ap_continue,
    output logic               ap_ready,
    output logic               ap_done,
    output logic               ap_idle,
    input  logic               op,
    input  logic [LANES*W-1:0] a_dout,
    input  logic               a_empty_n,
    output logic               a_read,
    input  logic [LANES*W-1:0] b_dout,
    input  logic               b_empty_n,
    output logic               b_read,
    output logic [LANES*W-1:0] z,
    output logic [LANES-1:0]   z_ovf,
    output logic               z_ap_vld
);

    ctrl_state_t        state;
    logic [LANES*W-1:0] a_q, b_q, lane_z;
    logic [LANES-1:0]   lane_ovf;
    logic               op_q, fire;

    // Joint pop only when both streams have data; reset masks strobes so nothing pops while held
    assign fire     = ap_rst_n && ap_ce && a_empty_n && b_empty_n &&
                      (state == WAIT_IN || (state == IDLE && ap_start));
    assign a_read   = fire;
    assign b_read   = fire;
    assign ap_ready = fire;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane_alu #(.W(W)) u_lane (
            .a  (a_q[i*W +: W]),
            .b  (b_q[i*W +: W]),
            .op (op_q),
            .r  (lane_z[i*W +: W]),
            .ovf(lane_ovf[i])
        );
    end

    // Control FSM with registered status, operand capture and result registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            z        <= '0;
            z_ovf    <= '0;
            z_ap_vld <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= 1'b0;
        end else if (ap_ce) begin
            z_ap_vld <= 1'b0;
            if (fire) begin
                a_q  <= a_dout;
                b_q  <= b_dout;
                op_q <= op;
            end
            case (state)
                IDLE: begin
                    ap_idle <= !(fire || ap_start);
                    state   <= fire ? EXEC : (ap_start ? WAIT_IN : IDLE);
                end
                WAIT_IN: state <= fire ? EXEC : WAIT_IN;
                EXEC: begin
                    z        <= lane_z;
                    z_ovf    <= lane_ovf;
                    z_ap_vld <= 1'b1;
                    ap_done  <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (ap_continue) begin
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_addsub_stream.sv
// tb_simd_addsub_stream: directed table-driven bench for simd_addsub_stream (honours SIMD_ADDSUB_SAT_EN)
module tb_simd_addsub_stream;

    localparam int L = 4;
    localparam int W = 11;

    logic           ap_clk = 1'b0, ap_rst_n = 1'b0, ap_ce = 1'b0;
    logic           ap_start = 1'b0, ap_continue = 1'b0, op = 1'b0;
    logic           a_empty_n = 1'b0, b_empty_n = 1'b0;
    logic [L*W-1:0] a_dout = '0, b_dout = '0;
    logic           ap_ready, ap_done, ap_idle, a_read, b_read, z_ap_vld;
    logic [L*W-1:0] z;
    logic [L-1:0]   z_ovf;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [L*W-1:0] a, b;
        logic           op;
        logic [L*W-1:0] zw, zs;
        logic [L-1:0]   ovf;
    } vec_t;

    vec_t v[6];
    vec_t sv;

    simd_addsub_stream #(.LANES(L), .W(W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_ce(ap_ce),
        .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .op(op),
        .a_dout(a_dout), .a_empty_n(a_empty_n), .a_read(a_read),
        .b_dout(b_dout), .b_empty_n(b_empty_n), .b_read(b_read),
        .z(z), .z_ovf(z_ovf), .z_ap_vld(z_ap_vld)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [L*W-1:0] pk(int l0, int l1, int l2, int l3);
        return {11'(l3), 11'(l2), 11'(l1), 11'(l0)};
    endfunction

    function automatic logic [L*W-1:0] ez(vec_t x);
`ifdef SIMD_ADDSUB_SAT_EN
        return x.zs;
`else
        return x.zw;
`endif
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Fire at cycle t, leave the bench at the t+2 negedge with the result checked
    task automatic fire_to_done(vec_t x, string nm);
        @(negedge ap_clk);
        a_dout = x.a; b_dout = x.b; op = x.op;
        a_empty_n = 1'b1; b_empty_n = 1'b1; ap_start = 1'b1;
        #1 chk({nm, " fire"}, {61'd0, a_read, b_read, ap_ready}, 64'd7);
        @(negedge ap_clk);
        ap_start = 1'b0; a_empty_n = 1'b0; b_empty_n = 1'b0;
        a_dout = '0; b_dout = '0; op = 1'b0;
        #1 chk({nm, " t+1 vld/rd"}, {62'd0, z_ap_vld, a_read}, 64'd0);
        @(negedge ap_clk);
        #1 chk({nm, " t+2 vld/done"}, {62'd0, z_ap_vld, ap_done}, 64'd3);
        chk({nm, " z"}, 64'(z), 64'(ez(x)));
        chk({nm, " z_ovf"}, 64'(z_ovf), 64'(x.ovf));
    endtask

    task automatic finish_call(string nm);
        ap_continue = 1'b1;
        @(negedge ap_clk);
        ap_continue = 1'b0;
        #1 chk({nm, " after continue vld/done/idle"}, {61'd0, z_ap_vld, ap_done, ap_idle}, 64'd1);
    endtask

    initial begin
        v[0] = '{pk(1, 2, 3, 1023), pk(1, 1, 1, 1), 1'b0,
                 pk(2, 3, 4, -1024), pk(2, 3, 4, 1023), 4'b1000};
        v[1] = '{pk(0, -1024, 5, 0), pk(1, 1, 5, 0), 1'b1,
                 pk(-1, 1023, 0, 0), pk(-1, -1024, 0, 0), 4'b0010};
        v[2] = '{pk(-1024, -1, 100, -500), pk(-1, -1, -200, 500), 1'b0,
                 pk(1023, -2, -100, 0), pk(-1024, -2, -100, 0), 4'b0001};
        v[3] = '{pk(1023, -1024, -1, 300), pk(-1, 0, -1024, -300), 1'b1,
                 pk(-1024, -1024, 1023, 600), pk(1023, -1024, 1023, 600), 4'b0001};
        v[4] = '{pk(511, 512, -512, 0), pk(512, 511, -512, 0), 1'b0,
                 pk(1023, 1023, -1024, 0), pk(1023, 1023, -1024, 0), 4'b0000};
        v[5] = '{pk(0, 0, 0, 0), pk(-1024, -1024, -1024, -1024), 1'b1,
                 pk(-1024, -1024, -1024, -1024), pk(1023, 1023, 1023, 1023), 4'b1111};
        sv   = '{pk(7, -8, 1000, -1000), pk(3, 8, 100, -100), 1'b0,
                 pk(10, 0, -948, 948), pk(10, 0, 1023, -1024), 4'b1100};

        // Reset state
        #1 chk("reset z", 64'(z), 64'd0);
        chk("reset ovf/vld/done/idle", {57'd0, z_ovf, z_ap_vld, ap_done, ap_idle}, 64'd0);
        ap_ce = 1'b1;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        #1 chk("idle after reset", {63'd0, ap_idle}, 64'd1);

        // Table-driven back-to-back calls
        for (int i = 0; i < 6; i++) begin
            fire_to_done(v[i], $sformatf("vec%0d", i));
            finish_call($sformatf("vec%0d", i));
        end

        // Stall: start with one stream empty
        @(negedge ap_clk);
        a_dout = sv.a; b_dout = sv.b; op = sv.op;
        ap_start = 1'b1; a_empty_n = 1'b0; b_empty_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("stall rd %0d", i), {62'd0, a_read, b_read}, 64'd0);
            @(negedge ap_clk);
        end
        ap_start = 1'b0; a_empty_n = 1'b1;
        #1 chk("stall idle", {63'd0, ap_idle}, 64'd0);
        chk("stall pop", {62'd0, a_read, b_read}, 64'd3);
        @(negedge ap_clk);
        a_empty_n = 1'b0; b_empty_n = 1'b0;
        #1 chk("stall single pop", {62'd0, a_read, b_read}, 64'd0);
        chk("stall t+1 vld", {63'd0, z_ap_vld}, 64'd0);
        @(negedge ap_clk);
        #1 chk("stall t+2 vld", {63'd0, z_ap_vld}, 64'd1);
        chk("stall z", 64'(z), 64'(ez(sv)));
        chk("stall z_ovf", 64'(z_ovf), 64'(sv.ovf));
        finish_call("stall");

        // Hold in DONE while start and data are available
        fire_to_done(v[0], "hold");
        ap_start = 1'b1; a_empty_n = 1'b1; b_empty_n = 1'b1; a_dout = v[1].a; b_dout = v[1].b;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            #1 chk($sformatf("hold done/vld/rd %0d", i), {60'd0, ap_done, z_ap_vld, a_read, b_read}, 64'd8);
            chk($sformatf("hold z %0d", i), 64'(z), 64'(ez(v[0])));
        end
        ap_start = 1'b0; a_empty_n = 1'b0; b_empty_n = 1'b0;
        finish_call("hold");

        // Clock enable: no fire while low, EXEC stretched by three cycles
        @(negedge ap_clk);
        ap_ce = 1'b0;
        a_dout = v[3].a; b_dout = v[3].b; op = v[3].op;
        ap_start = 1'b1; a_empty_n = 1'b1; b_empty_n = 1'b1;
        #1 chk("ce low no pop", {62'd0, a_read, b_read}, 64'd0);
        @(negedge ap_clk);
        ap_ce = 1'b1;
        #1 chk("ce fire", {62'd0, a_read, b_read}, 64'd3);
        @(negedge ap_clk);
        ap_ce = 1'b0; ap_start = 1'b0;
        #1 chk("ce t+1 rd/vld", {61'd0, a_read, b_read, z_ap_vld}, 64'd0);
        for (int i = 2; i < 4; i++) begin
            @(negedge ap_clk);
            #1 chk($sformatf("ce frozen t+%0d", i), {60'd0, a_read, b_read, z_ap_vld, ap_done}, 64'd0);
            chk($sformatf("ce z t+%0d", i), 64'(z), 64'(ez(v[0])));
        end
        @(negedge ap_clk);
        ap_ce = 1'b1; a_empty_n = 1'b0; b_empty_n = 1'b0;
        #1 chk("ce t+4 vld", {63'd0, z_ap_vld}, 64'd0);
        @(negedge ap_clk);
        #1 chk("ce t+5 vld/done", {62'd0, z_ap_vld, ap_done}, 64'd3);
        chk("ce z", 64'(z), 64'(ez(v[3])));
        finish_call("ce");

        // Asynchronous reset mid-EXEC
        @(negedge ap_clk);
        a_dout = v[5].a; b_dout = v[5].b; op = v[5].op;
        ap_start = 1'b1; a_empty_n = 1'b1; b_empty_n = 1'b1;
        #1 chk("rst fire", {62'd0, a_read, b_read}, 64'd3);
        @(negedge ap_clk);
        ap_start = 1'b0;
        ap_rst_n = 1'b0;
        #1 chk("rst z", 64'(z), 64'd0);
        chk("rst ovf/idle/vld/rd", {56'd0, z_ovf, ap_idle, z_ap_vld, a_read, b_read}, 64'd0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1 chk("rst release rd/idle", {61'd0, a_read, b_read, ap_idle}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            #1 chk($sformatf("post-rst idle/rd/vld %0d", i), {60'd0, ap_idle, a_read, b_read, z_ap_vld}, 64'd8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
